// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default bit period and
// frame length. Optional feature macro: UART_TX_PARITY_EN (even parity bit
// inserted between d7 and stop, frame grows from 10 to 11 bits).
package uart_pkg;

  typedef enum logic {
    IDLE         = 1'b0,
    TRANSMITTING = 1'b1
  } tx_state_t;

  // 19200 baud from a 50 MHz clock; receiver and transmitter share it.
  localparam int BAUD_DIV_DEFAULT = 2604;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // The stop bit comes from the 1-fill of the shift register, so the
  // register only needs to hold start + data (+ parity).
  localparam int SHIFT_W = FRAME_BITS - 1;

  // Serialisation image of one byte, LSB transmitted first.
  function automatic logic [SHIFT_W-1:0] build_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {^d, d, 1'b0};
`else
    return {d, 1'b0};
`endif
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Command-side interface of the UART transmitter.
// Handshake: trmt is a single-cycle strobe with tx_data valid in the same
// cycle; it is accepted only while busy is low, and ignored while a frame is
// in flight. tx_done is sticky from the end of a stop bit until the next
// accepted trmt. state mirrors the FSM register for debug/checkers.
interface uart_tx_if import uart_pkg::*; ();

  logic       trmt;
  logic [7:0] tx_data;
  logic       TX;
  logic       tx_done;
  logic       busy;
  tx_state_t  state;

  modport master (
    output trmt, tx_data,
    input  TX, tx_done, busy, state
  );

  modport slave (
    input  trmt, tx_data,
    output TX, tx_done, busy, state
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; with UART_TX_PARITY_EN an even parity
// bit is sent between d7 and stop. TX is the LSB of the shift register, so
// the line is registered and glitch-free.
module uart_tx import uart_pkg::*; #(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT  // clocks per bit, 16..4095
) (
  input logic     clk,
  input logic     rst,
  uart_tx_if.slave bus
);

  localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT    = 4'(FRAME_BITS - 1);

  tx_state_t          r_state;
  logic [11:0]        r_baud_cnt;
  logic [3:0]         r_bit_cnt;
  logic [SHIFT_W-1:0] r_shift_reg;
  logic               r_tx_done;

  tx_state_t          w_state;
  logic [11:0]        w_baud_cnt;
  logic [3:0]         w_bit_cnt;
  logic [SHIFT_W-1:0] w_shift_reg;
  logic               w_tx_done;

  // State and datapath registers; reset returns the line to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift_reg <= '1;
      r_tx_done   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_baud_cnt  <= w_baud_cnt;
      r_bit_cnt   <= w_bit_cnt;
      r_shift_reg <= w_shift_reg;
      r_tx_done   <= w_tx_done;
    end
  end

  // Next-state: accept a byte in IDLE, then shift one bit per baud period
  // until the stop bit has been held for a full period.
  always_comb begin
    w_state     = r_state;
    w_baud_cnt  = r_baud_cnt;
    w_bit_cnt   = r_bit_cnt;
    w_shift_reg = r_shift_reg;
    w_tx_done   = r_tx_done;
    case (r_state)
      IDLE: begin
        if (bus.trmt) begin
          w_shift_reg = build_frame(bus.tx_data);
          w_baud_cnt  = BAUD_RELOAD;
          w_bit_cnt   = 4'd0;
          w_tx_done   = 1'b0;
          w_state     = TRANSMITTING;
        end
      end
      TRANSMITTING: begin
        if (r_baud_cnt == 12'd0) begin
          // Filling with 1 leaves the register all-ones after the last data
          // bit, which provides the stop bit and the idle level.
          w_shift_reg = {1'b1, r_shift_reg[SHIFT_W-1:1]};
          w_bit_cnt   = r_bit_cnt + 4'd1;
          w_baud_cnt  = BAUD_RELOAD;
          if (r_bit_cnt == LAST_BIT) begin
            w_tx_done = 1'b1;
            w_state   = IDLE;
          end
        end else begin
          w_baud_cnt = r_baud_cnt - 12'd1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.TX      = r_shift_reg[0];
  assign bus.tx_done = r_tx_done;
  assign bus.busy    = (r_state == TRANSMITTING);
  assign bus.state   = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at BAUD_DIV=16: random and directed bytes, each frame's
// expected line levels built as a bit queue from the byte (start, LSBs first,
// optional even parity, stop) and compared cycle by cycle.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int B = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_done = 1'b0;
  logic [0:0] exp_q[$];

  // Clock and DUT
  always #5 clk = ~clk;

  uart_tx_if bus();

  uart_tx #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Idle line for n cycles; called and returns at a negedge.
  task automatic idle_check(input int n);
    repeat (n) begin
      chk("idle_tx", 32'(bus.TX), 32'd1);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.tx_done), 32'(exp_done));
      chk("idle_state", 32'(bus.state), 32'(IDLE));
      @(negedge clk);
    end
  endtask

  // Send one byte starting at the current negedge. Returns at the negedge of
  // the first cycle after the frame, so a caller may start another at once.
  // poke: pulse trmt with 0x11 70 cycles into the frame.
  task automatic send_frame(input logic [7:0] d, input bit poke);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);

    bus.trmt    = 1'b1;
    bus.tx_data = d;
    @(negedge clk);
    for (int t = 1; t <= exp_q.size() * B; t++) begin
      bus.trmt    = poke && (t == 70);
      bus.tx_data = (poke && t == 70) ? 8'h11 : 8'($urandom);
      chk("tx_bit", 32'(bus.TX), 32'(exp_q[(t - 1) / B]));
      chk("busy", 32'(bus.busy), 32'd1);
      chk("done_early", 32'(bus.tx_done), 32'd0);
      @(negedge clk);
    end
    bus.trmt = 1'b0;
    exp_done = 1'b1;
    chk("done_rise", 32'(bus.tx_done), 32'd1);
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("tx_after_stop", 32'(bus.TX), 32'd1);
  endtask

  // Start a frame, then reset 70 cycles into it.
  task automatic abort_frame(input logic [7:0] d);
    bus.trmt    = 1'b1;
    bus.tx_data = d;
    @(negedge clk);
    bus.trmt = 1'b0;
    repeat (69) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_done = 1'b0;
    chk("abort_tx", 32'(bus.TX), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.tx_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Stimulus sequence and final report
  initial begin
    bus.trmt    = 1'b0;
    bus.tx_data = 8'h00;
    rst         = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", 32'(bus.TX), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.tx_done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    idle_check(200);

    send_frame(8'hA5, 1'b0);
    idle_check(3);

    repeat (6) begin
      send_frame(8'($urandom), 1'b0);
      idle_check($urandom_range(1, 20));
    end

    send_frame(8'h5A, 1'b1);
    idle_check(2);

    send_frame(8'h3C, 1'b0);
    send_frame(8'h81, 1'b0);
    idle_check(2);

    abort_frame(8'hC3);
    idle_check(5);
    send_frame(8'h42, 1'b0);
    idle_check(2);

    send_frame(8'h07, 1'b0);
    send_frame(8'h00, 1'b0);
    idle_check(1);
    send_frame(8'hFF, 1'b0);
    idle_check(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
